reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  Circular in-order retirement buffer; allocates the ROB ids used as dest/Qj/Qk by the reservation stations.
//  Captures ALU and MEM CDB broadcasts and answers decoder operand queries, with same-cycle CDB bypass.
//  Commits one ready head entry per cycle to the register file or the store unit.
//  Detects branch mispredicts at commit and raises flush_output.
// PARAMETERS
//  ROB_W     4   id width; ROB_SIZE = 2**ROB_W-1 = 15 entries, ids 1..15, id 0 = "none/invalid"
// PORTS
//  clk_in          in   1      system clock
//  rst_n_in        in   1      reset, asynchronous, active-low
//  flush_input     in   1      synchronous external flush
//  issue_valid     in   1      allocate an entry this cycle
//  issue_type      in   2      0=reg write, 1=branch, 2=store
//  issue_rd        in   5      destination register (type 0)
//  issue_pred      in   1      predicted taken (type 1)
//  issue_alt_pc    in   32     redirect PC if mispredicted (type 1)
//  issue_rob_id    out  ROB_W  id the next allocation receives (= tail), combinational
//  rob_full        out  1      count==ROB_SIZE, combinational
//  cdb_alu_rob_id  in   ROB_W  ALU result id, 0 = none
//  cdb_alu_value   in   32     ALU result
//  cdb_mem_rob_id  in   ROB_W  MEM result id, 0 = none
//  cdb_mem_value   in   32     MEM result
//  qj_id/qk_id     in   ROB_W  operand query ids (one port each)
//  qj_ready/qk_ready  out 1    entry holds a value, combinational
//  qj_value/qk_value  out 32   that value, combinational
//  commit_rob_id   out  ROB_W  retired id, 0 = none this cycle, registered
//  commit_rd       out  5      regfile write index, 0 = no write, registered
//  commit_value    out  32     regfile write data, registered
//  store_commit    out  1      head store retired, one-cycle pulse
//  flush_output    out  1      mispredict flush, one-cycle pulse
//  redirect_pc     out  32     new PC, valid while flush_output=1
// BEHAVIOUR
//  - Reset: all registered outputs 0; head=tail=1; count=0; busy/ready cleared.
//  - Wrap-around: pointers step 1..15 and then back to 1; 0 is never allocated.
//  - Issue: when issue_valid and !rob_full, the clock edge writes the entry at tail and sets busy=1, ready=0.
//    It also advances tail and increments count.
//  - Issue while full is dropped silently; the decoder must honour rob_full.
//  - CDB: each non-zero cdb id whose entry is busy sets ready=1 and value at the edge.
//    ALU and MEM may write different ids in the same cycle.
//  - A CDB id that names a non-busy entry is ignored.
//  - Query: if id==0, ready=1 and value=0.
//  - Query bypass: if the id matches the cdb_alu id, return the ALU value with ready=1.
//    Otherwise, if it matches the cdb_mem id, return the MEM value with ready=1.
//  - Query otherwise: return the stored ready bit and value.
//  - Commit: at an edge where the head is busy and ready, retire it, so latency is CDB edge N -> commit edge N+1.
//    Retirement advances head, decrements count and drives commit_rob_id=head.
//  - Commit, type 0: commit_rd=rd, commit_value=value.
//  - Commit, type 2: store_commit=1 and commit_rd=0.
//  - Commit, type 1: commit_rd=0. If value[0]!=pred, flush_output=1 and redirect_pc=alt_pc.
//    At the same edge all entries are cleared: head=tail=1, count=0.
//  - If no commit occurs, commit_rob_id=0, commit_rd=0, store_commit=0 and flush_output=0 on the next cycle.
//  - Simultaneous issue and commit: count is unchanged, and a full buffer stays full.
//  - A mispredict commit takes priority over a simultaneous issue; the issue is discarded.
//  - flush_input: clears the state exactly like a mispredict. It has priority over issue, CDB and commit.
//    During flush_input, all commit outputs are 0 next cycle and flush_output is not asserted.
//  - Reset asserted mid-operation forces the reset state immediately, asynchronously.
// TESTING
//  - Issue 3 type-0 (rd=1,2,3) -> issue_rob_id 1,2,3; then ALU CDB id2=0x22 -> no commit (head 1 not ready).
//    Then CDB id1=0x11 -> commits 1 then 2 on consecutive cycles, with commit_rd=1/2.
//  - Fill 15 entries -> rob_full=1; a 16th issue is dropped.
//    Resolve and commit 15 -> head wraps to 1, and a new issue gets id 1.
//  - Query qj_id=5 while cdb_alu_rob_id=5, value=0xDEAD -> qj_ready=1, qj_value=0xDEAD in the same cycle.
//  - Branch pred=0, CDB value=1, alt_pc=0x1000 -> at commit: flush_output=1 for one cycle, redirect_pc=0x1000.
//    Then rob_full=0 and issue_rob_id=1.
//  - ALU id3=7 and MEM id4=9 in the same cycle -> both entries ready; a store at head -> store_commit pulse, commit_rd=0.
//  - Deassert rst_n_in mid-stream, off clock edge -> outputs 0 immediately; flush_input with issue_valid -> issue ignored.

Source files
------------

// File: rtl/reorder_buffer.sv
// Reorder buffer: circular in-order retirement buffer for a Tomasulo-style core.
//
// Allocates ROB ids 1..2**ROB_W-1 (id 0 means "none"). It captures ALU and MEM
// CDB results and answers two operand queries, with a same-cycle CDB bypass.
// One ready head entry retires per cycle. Branch mispredicts are detected at
// commit and raise a one-cycle flush.
//
// Ports:
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   flush_input               synchronous external flush (clears all entries)
//   issue_*                   allocation request: type (0 reg, 1 branch, 2 store),
//                             rd, predicted-taken, redirect PC
//   issue_rob_id, rob_full    id the next allocation receives; buffer-full flag
//   cdb_alu_*, cdb_mem_*      result broadcasts (id 0 = no broadcast)
//   qj_*/qk_*                 operand query id -> ready/value (combinational)
//   commit_rob_id/rd/value    registered retirement info (rd 0 = no regfile write)
//   store_commit              head store retired (pulse)
//   flush_output, redirect_pc mispredict flush pulse and target PC
module reorder_buffer #(
  parameter int unsigned ROB_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             flush_input,
  input  logic             issue_valid,
  input  logic [1:0]       issue_type,
  input  logic [4:0]       issue_rd,
  input  logic             issue_pred,
  input  logic [31:0]      issue_alt_pc,
  output logic [ROB_W-1:0] issue_rob_id,
  output logic             rob_full,
  input  logic [ROB_W-1:0] cdb_alu_rob_id,
  input  logic [31:0]      cdb_alu_value,
  input  logic [ROB_W-1:0] cdb_mem_rob_id,
  input  logic [31:0]      cdb_mem_value,
  input  logic [ROB_W-1:0] qj_id,
  input  logic [ROB_W-1:0] qk_id,
  output logic             qj_ready,
  output logic [31:0]      qj_value,
  output logic             qk_ready,
  output logic [31:0]      qk_value,
  output logic [ROB_W-1:0] commit_rob_id,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_value,
  output logic             store_commit,
  output logic             flush_output,
  output logic [31:0]      redirect_pc
);

  localparam int unsigned Depth   = 2 ** ROB_W;
  localparam int unsigned RobSize = Depth - 1;

  typedef logic [ROB_W-1:0] id_t;

  localparam logic [1:0] TypeReg    = 2'd0;
  localparam logic [1:0] TypeBranch = 2'd1;
  localparam logic [1:0] TypeStore  = 2'd2;

  localparam id_t IdFirst = id_t'(1);
  localparam id_t IdLast  = id_t'(RobSize);

  // Pointer increment that skips id 0.
  function automatic id_t next_ptr(input id_t p);
    return (p == IdLast) ? IdFirst : p + id_t'(1);
  endfunction

  // Control state
  id_t              head_q, head_d;
  id_t              tail_q, tail_d;
  id_t              count_q, count_d;
  logic [Depth-1:0] busy_q, busy_d;
  logic [Depth-1:0] ready_q, ready_d;

  // Entry payload; slot 0 is never allocated. Validity is tracked by busy/ready.
  logic [1:0]  type_q  [Depth];
  logic [4:0]  rd_q    [Depth];
  logic        pred_q  [Depth];
  logic [31:0] alt_q   [Depth];
  logic [31:0] value_q [Depth];

  // Registered outputs
  id_t         commit_rob_id_q, commit_rob_id_d;
  logic [4:0]  commit_rd_q, commit_rd_d;
  logic [31:0] commit_value_q, commit_value_d;
  logic        store_commit_q, store_commit_d;
  logic        flush_output_q, flush_output_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic commit_fire;
  logic mispredict;
  logic clear_all;
  logic issue_fire;
  logic alu_wr;
  logic mem_wr;

  assign issue_rob_id = tail_q;
  assign rob_full     = (count_q == IdLast);

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    commit_fire = !flush_input && busy_q[head_q] && ready_q[head_q];
    mispredict  = commit_fire && (type_q[head_q] == TypeBranch) &&
                  (value_q[head_q][0] != pred_q[head_q]);
    clear_all   = flush_input || mispredict;
    // When full, the head slot frees at this edge, so the tail (== head) can be
    // reused immediately and the buffer stays full.
    issue_fire  = issue_valid && !clear_all && (!rob_full || commit_fire);
    alu_wr      = !clear_all && (cdb_alu_rob_id != '0) && busy_q[cdb_alu_rob_id];
    mem_wr      = !clear_all && (cdb_mem_rob_id != '0) && busy_q[cdb_mem_rob_id];
  end

  // ---------------------------------------------------------------------------
  // Next-state for pointers and per-entry flags
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (alu_wr) ready_d[cdb_alu_rob_id] = 1'b1;
    if (mem_wr) ready_d[cdb_mem_rob_id] = 1'b1;

    if (commit_fire) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = next_ptr(head_q);
    end

    // Applied after the commit clear so a reused full-buffer slot ends up busy.
    if (issue_fire) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      tail_d          = next_ptr(tail_q);
    end

    if (issue_fire && !commit_fire) begin
      count_d = count_q + id_t'(1);
    end else if (!issue_fire && commit_fire) begin
      count_d = count_q - id_t'(1);
    end

    if (clear_all) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = IdFirst;
      tail_d  = IdFirst;
      count_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state for registered commit outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    commit_rob_id_d = '0;
    commit_rd_d     = '0;
    commit_value_d  = '0;
    store_commit_d  = 1'b0;
    flush_output_d  = 1'b0;
    redirect_pc_d   = '0;

    if (commit_fire) begin
      commit_rob_id_d = head_q;
      unique case (type_q[head_q])
        TypeReg: begin
          commit_rd_d    = rd_q[head_q];
          commit_value_d = value_q[head_q];
        end
        TypeStore: begin
          store_commit_d = 1'b1;
        end
        TypeBranch: begin
          if (mispredict) begin
            flush_output_d = 1'b1;
            redirect_pc_d  = alt_q[head_q];
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q          <= IdFirst;
      tail_q          <= IdFirst;
      count_q         <= '0;
      busy_q          <= '0;
      ready_q         <= '0;
      commit_rob_id_q <= '0;
      commit_rd_q     <= '0;
      commit_value_q  <= '0;
      store_commit_q  <= 1'b0;
      flush_output_q  <= 1'b0;
      redirect_pc_q   <= '0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      busy_q          <= busy_d;
      ready_q         <= ready_d;
      commit_rob_id_q <= commit_rob_id_d;
      commit_rd_q     <= commit_rd_d;
      commit_value_q  <= commit_value_d;
      store_commit_q  <= store_commit_d;
      flush_output_q  <= flush_output_d;
      redirect_pc_q   <= redirect_pc_d;
    end
  end

  // Payload storage needs no reset: stale contents are masked by busy/ready.
  always_ff @(posedge clk_in) begin
    if (issue_fire) begin
      type_q[tail_q] <= issue_type;
      rd_q[tail_q]   <= issue_rd;
      pred_q[tail_q] <= issue_pred;
      alt_q[tail_q]  <= issue_alt_pc;
    end
    if (mem_wr) value_q[cdb_mem_rob_id] <= cdb_mem_value;
    if (alu_wr) value_q[cdb_alu_rob_id] <= cdb_alu_value;
  end

  assign commit_rob_id = commit_rob_id_q;
  assign commit_rd     = commit_rd_q;
  assign commit_value  = commit_value_q;
  assign store_commit  = store_commit_q;
  assign flush_output  = flush_output_q;
  assign redirect_pc   = redirect_pc_q;

  // ---------------------------------------------------------------------------
  // Operand queries: id 0 is a constant zero, then ALU bypass, MEM bypass, store.
  // ---------------------------------------------------------------------------
  always_comb begin
    qj_ready = ready_q[qj_id];
    qj_value = value_q[qj_id];
    if (qj_id == '0) begin
      qj_ready = 1'b1;
      qj_value = '0;
    end else if (qj_id == cdb_alu_rob_id) begin
      qj_ready = 1'b1;
      qj_value = cdb_alu_value;
    end else if (qj_id == cdb_mem_rob_id) begin
      qj_ready = 1'b1;
      qj_value = cdb_mem_value;
    end
  end

  always_comb begin
    qk_ready = ready_q[qk_id];
    qk_value = value_q[qk_id];
    if (qk_id == '0) begin
      qk_ready = 1'b1;
      qk_value = '0;
    end else if (qk_id == cdb_alu_rob_id) begin
      qk_ready = 1'b1;
      qk_value = cdb_alu_value;
    end else if (qk_id == cdb_mem_rob_id) begin
      qk_ready = 1'b1;
      qk_value = cdb_mem_value;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        flush_input;
  logic        issue_valid;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic        issue_pred;
  logic [31:0] issue_alt_pc;
  logic [3:0]  issue_rob_id;
  logic        rob_full;
  logic [3:0]  cdb_alu_rob_id;
  logic [31:0] cdb_alu_value;
  logic [3:0]  cdb_mem_rob_id;
  logic [31:0] cdb_mem_value;
  logic [3:0]  qj_id;
  logic [3:0]  qk_id;
  logic        qj_ready;
  logic [31:0] qj_value;
  logic        qk_ready;
  logic [31:0] qk_value;
  logic [3:0]  commit_rob_id;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic        store_commit;
  logic        flush_output;
  logic [31:0] redirect_pc;

  always #5 clk_in = ~clk_in;

  reorder_buffer #(.ROB_W(4)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .flush_input    (flush_input),
    .issue_valid    (issue_valid),
    .issue_type     (issue_type),
    .issue_rd       (issue_rd),
    .issue_pred     (issue_pred),
    .issue_alt_pc   (issue_alt_pc),
    .issue_rob_id   (issue_rob_id),
    .rob_full       (rob_full),
    .cdb_alu_rob_id (cdb_alu_rob_id),
    .cdb_alu_value  (cdb_alu_value),
    .cdb_mem_rob_id (cdb_mem_rob_id),
    .cdb_mem_value  (cdb_mem_value),
    .qj_id          (qj_id),
    .qk_id          (qk_id),
    .qj_ready       (qj_ready),
    .qj_value       (qj_value),
    .qk_ready       (qk_ready),
    .qk_value       (qk_value),
    .commit_rob_id  (commit_rob_id),
    .commit_rd      (commit_rd),
    .commit_value   (commit_value),
    .store_commit   (store_commit),
    .flush_output   (flush_output),
    .redirect_pc    (redirect_pc)
  );

  typedef struct {
    logic [3:0]  id;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic        pred;
    logic [31:0] alt;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] m_val [16];
  logic [3:0]  m_tail;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [3:0] nxt(input logic [3:0] p);
    return (p == 4'd15) ? 4'd1 : p + 4'd1;
  endfunction

  task automatic do_issue(input logic [1:0] typ, input logic [4:0] rd, input logic pred,
                          input logic [31:0] alt, input bit accept);
    ent_t e;
    chk("issue_rob_id", 32'(issue_rob_id), 32'(m_tail));
    issue_valid  = 1'b1;
    issue_type   = typ;
    issue_rd     = rd;
    issue_pred   = pred;
    issue_alt_pc = alt;
    cycle();
    issue_valid  = 1'b0;
    if (accept) begin
      e.id = m_tail; e.typ = typ; e.rd = rd; e.pred = pred; e.alt = alt;
      sb.push_back(e);
      m_tail = nxt(m_tail);
    end
  endtask

  task automatic cdb(input logic [3:0] aid, input logic [31:0] aval,
                     input logic [3:0] mid, input logic [31:0] mval);
    cdb_alu_rob_id = aid;
    cdb_alu_value  = aval;
    cdb_mem_rob_id = mid;
    cdb_mem_value  = mval;
    if (aid != 4'd0) m_val[aid] = aval;
    if (mid != 4'd0) m_val[mid] = mval;
    cycle();
    cdb_alu_rob_id = '0;
    cdb_mem_rob_id = '0;
  endtask

  task automatic expect_commit();
    ent_t e;
    logic exp_flush;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      exp_flush = (e.typ == 2'd1) && (m_val[e.id][0] != e.pred);
      chk("commit_rob_id", 32'(commit_rob_id), 32'(e.id));
      chk("commit_rd", 32'(commit_rd), (e.typ == 2'd0) ? 32'(e.rd) : 32'd0);
      if (e.typ == 2'd0) chk("commit_value", commit_value, m_val[e.id]);
      chk("store_commit", 32'(store_commit), (e.typ == 2'd2) ? 32'd1 : 32'd0);
      chk("flush_output", 32'(flush_output), 32'(exp_flush));
      if (exp_flush) chk("redirect_pc", redirect_pc, e.alt);
    end
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_commit_id"}, 32'(commit_rob_id), 32'd0);
    chk({tag, "_commit_rd"}, 32'(commit_rd), 32'd0);
    chk({tag, "_store"}, 32'(store_commit), 32'd0);
    chk({tag, "_flush"}, 32'(flush_output), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n_in = 1'b0; flush_input = 1'b0; issue_valid = 1'b0; issue_type = '0;
    issue_rd = '0; issue_pred = 1'b0; issue_alt_pc = '0;
    cdb_alu_rob_id = '0; cdb_alu_value = '0; cdb_mem_rob_id = '0; cdb_mem_value = '0;
    qj_id = '0; qk_id = '0;
    for (int i = 0; i < 16; i++) m_val[i] = '0;
    m_tail = 4'd1;

    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_commit_id", 32'(commit_rob_id), 32'd0);
    chk("rst_commit_rd", 32'(commit_rd), 32'd0);
    chk("rst_commit_value", commit_value, 32'd0);
    chk("rst_store", 32'(store_commit), 32'd0);
    chk("rst_flush", 32'(flush_output), 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    chk("rst_issue_id", 32'(issue_rob_id), 32'd1);
    chk("rst_full", 32'(rob_full), 32'd0);
    rst_n_in = 1'b1;

    // In-order commit: id2 resolves first but waits for head id1
    do_issue(2'd0, 5'd1, 1'b0, 32'd0, 1'b1);
    do_issue(2'd0, 5'd2, 1'b0, 32'd0, 1'b1);
    do_issue(2'd0, 5'd3, 1'b0, 32'd0, 1'b1);
    cdb(4'd2, 32'h22, 4'd0, 32'd0);
    expect_idle("t1_a");
    cycle();
    expect_idle("t1_b");
    cdb(4'd1, 32'h11, 4'd0, 32'd0);
    expect_idle("t1_c");
    cycle(); expect_commit();
    cycle(); expect_commit();
    cycle(); expect_idle("t1_d");
    cdb(4'd0, 32'd0, 4'd3, 32'h33);
    cycle(); expect_commit();

    // Fill, drop when full, resolve out of order, commit all with wrap
    flush_input = 1'b1;
    cycle();
    flush_input = 1'b0;
    expect_idle("t2_flush");
    sb.delete();
    m_tail = 4'd1;
    for (int i = 0; i < 15; i++) do_issue(2'd0, 5'(i + 1), 1'b0, 32'd0, 1'b1);
    chk("t2_full", 32'(rob_full), 32'd1);
    do_issue(2'd0, 5'd20, 1'b0, 32'd0, 1'b0);
    chk("t2_full_after_drop", 32'(rob_full), 32'd1);
    chk("t2_id_after_drop", 32'(issue_rob_id), 32'd1);
    for (int k = 2; k <= 14; k += 2) begin
      cdb(4'(k), 32'h100 + 32'(k), 4'(k + 1), 32'h100 + 32'(k + 1));
      chk("t2_no_commit", 32'(commit_rob_id), 32'd0);
    end
    cdb(4'd1, 32'h101, 4'd0, 32'd0);
    chk("t2_no_commit_head", 32'(commit_rob_id), 32'd0);
    for (int i = 0; i < 15; i++) begin
      cycle();
      expect_commit();
    end
    chk("t2_empty_full", 32'(rob_full), 32'd0);
    chk("t2_wrap_id", 32'(issue_rob_id), 32'd1);
    cycle();
    expect_idle("t2_done");

    // Query bypass and id 0
    qj_id = 4'd5; cdb_alu_rob_id = 4'd5; cdb_alu_value = 32'hDEAD; qk_id = 4'd0;
    #1;
    chk("t3_qj_ready", 32'(qj_ready), 32'd1);
    chk("t3_qj_value", qj_value, 32'hDEAD);
    chk("t3_qk0_ready", 32'(qk_ready), 32'd1);
    chk("t3_qk0_value", qk_value, 32'd0);
    qk_id = 4'd6; cdb_mem_rob_id = 4'd6; cdb_mem_value = 32'hBEEF;
    #1;
    chk("t3_qk_mem_value", qk_value, 32'hBEEF);
    qj_id = 4'd7; cdb_alu_rob_id = 4'd7; cdb_alu_value = 32'hA; cdb_mem_rob_id = 4'd7;
    cdb_mem_value = 32'hB;
    #1;
    chk("t3_alu_priority", qj_value, 32'hA);
    cdb_alu_rob_id = '0; cdb_mem_rob_id = '0; qj_id = '0; qk_id = '0;

    // Branch mispredict flushes and discards a same-edge issue
    do_issue(2'd0, 5'd9, 1'b0, 32'd0, 1'b1);
    do_issue(2'd1, 5'd0, 1'b0, 32'h1000, 1'b1);
    do_issue(2'd0, 5'd4, 1'b0, 32'd0, 1'b1);
    cdb(4'd2, 32'd1, 4'd1, 32'h55);
    expect_idle("t4_a");
    cycle(); expect_commit();
    issue_valid = 1'b1; issue_type = 2'd0; issue_rd = 5'd12;
    cycle();
    issue_valid = 1'b0;
    expect_commit();
    sb.delete();
    m_tail = 4'd1;
    chk("t4_full", 32'(rob_full), 32'd0);
    chk("t4_issue_id", 32'(issue_rob_id), 32'd1);
    qj_id = 4'd3;
    #1;
    chk("t4_cleared_entry", 32'(qj_ready), 32'd0);
    qj_id = '0;
    cycle();
    expect_idle("t4_pulse_end");
    chk("t4_issue_id_after", 32'(issue_rob_id), 32'd1);

    // Dual CDB write, stored query path, store commit pulse
    do_issue(2'd2, 5'd0, 1'b0, 32'd0, 1'b1);
    do_issue(2'd0, 5'd6, 1'b0, 32'd0, 1'b1);
    do_issue(2'd0, 5'd7, 1'b0, 32'd0, 1'b1);
    do_issue(2'd0, 5'd8, 1'b0, 32'd0, 1'b1);
    cdb(4'd3, 32'd7, 4'd4, 32'd9);
    expect_idle("t5_a");
    qj_id = 4'd3; qk_id = 4'd4;
    #1;
    chk("t5_qj_ready", 32'(qj_ready), 32'd1);
    chk("t5_qj_value", qj_value, 32'd7);
    chk("t5_qk_ready", 32'(qk_ready), 32'd1);
    chk("t5_qk_value", qk_value, 32'd9);
    qj_id = '0; qk_id = '0;
    cdb(4'd1, 32'd0, 4'd0, 32'd0);
    expect_idle("t5_b");
    cycle(); expect_commit();
    cycle(); expect_idle("t5_store_pulse");
    cdb(4'd2, 32'h66, 4'd0, 32'd0);
    expect_idle("t5_c");
    cycle(); expect_commit();
    cycle(); expect_commit();
    cycle(); expect_commit();
    cycle(); expect_idle("t5_done");

    // Asynchronous reset mid-stream
    do_issue(2'd0, 5'd5, 1'b0, 32'd0, 1'b1);
    cdb(4'd5, 32'h77, 4'd0, 32'd0);
    cycle(); expect_commit();
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("t6_rst_commit_id", 32'(commit_rob_id), 32'd0);
    chk("t6_rst_commit_rd", 32'(commit_rd), 32'd0);
    chk("t6_rst_commit_value", commit_value, 32'd0);
    chk("t6_rst_issue_id", 32'(issue_rob_id), 32'd1);
    chk("t6_rst_full", 32'(rob_full), 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    sb.delete();
    m_tail = 4'd1;

    // flush_input beats a ready commit, an issue and a CDB write
    do_issue(2'd0, 5'd3, 1'b0, 32'd0, 1'b1);
    cdb(4'd1, 32'd5, 4'd0, 32'd0);
    flush_input = 1'b1; issue_valid = 1'b1; issue_type = 2'd0; issue_rd = 5'd2;
    cycle();
    flush_input = 1'b0; issue_valid = 1'b0;
    expect_idle("t6_flush");
    chk("t6_flush_issue_id", 32'(issue_rob_id), 32'd1);
    chk("t6_flush_full", 32'(rob_full), 32'd0);
    qj_id = 4'd1;
    #1;
    chk("t6_flush_cleared", 32'(qj_ready), 32'd0);
    qj_id = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
